imem_loader: RTL

- Boot-time writer for the byte-wide instruction memory. It accepts a byte stream over a valid/ready handshake and writes payload bytes one per cycle into consecutive byte addresses.
- Address order is identical to the fetch side: the byte at address A is instruction bits [31:24], A+1 is [23:16], and so on.
- It holds the core in reset until a load completes with a correct checksum.
- It sits between the host byte source (UART RX or testbench) and the write port of the instruction memory.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// frame constants and the checksum rule.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } loader_state_t;

   localparam int LEN_BYTES = 4;

   // Additive checksum: payload bytes plus CS must wrap to this value.
   localparam logic [7:0] CSUM_TARGET = 8'h00;

   function automatic logic csum_ok(input logic [7:0] acc, input logic [7:0] b);
      logic [7:0] total;
      total = 8'(acc + b);
      return total == CSUM_TARGET;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, memory byte-write port out. The host side drives the stream
// and observes the write port; the loader side is the opposite.
interface imem_loader_if #(
   parameter int AW = 32
);
   // A byte transfers on a rising clk edge where in_valid && in_ready; in_ready
   // never depends on in_valid, and the source holds in_data stable while valid.
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] address;
   logic [7:0]    data;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, address, data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, address, data
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses LEN(4, big-endian) | payload | CS frames and writes
// payload bytes to consecutive addresses, holding the core until a good load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int            AW        = 32,
   parameter int            MEM_BYTES = 1024,
   parameter logic [AW-1:0] BASE_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] load_count,
   output loader_state_t state
);

   loader_state_t state_q, state_d;

   logic [AW-1:0] len_q;
   logic [AW-1:0] index_q;
   logic [1:0]    len_cnt_q;
   logic [7:0]    acc_q;

   logic          xfer;
   logic          start_ok;
   logic [AW-1:0] len_next;

   assign xfer     = bus.in_valid && bus.in_ready;
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
   assign len_next = {len_q[AW-9:0], bus.in_data};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (xfer && (len_cnt_q == 2'(LEN_BYTES - 1))) begin
               if (len_next > AW'(MEM_BYTES)) state_d = ST_ERR;
               else if (len_next == '0)       state_d = ST_CSUM;
               else                           state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (xfer && (index_q == len_q - AW'(1))) state_d = ST_CSUM;
         end
         ST_CSUM: begin
            if (xfer) state_d = csum_ok(acc_q, bus.in_data) ? ST_DONE : ST_ERR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are pure functions of state so they track reset immediately.
   always_comb begin
      bus.in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
      done         = (state_q == ST_DONE);
      error        = (state_q == ST_ERR);
      cpu_hold     = (state_q != ST_DONE);
      state        = state_q;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q       <= '0;
         len_cnt_q   <= '0;
         index_q     <= '0;
         acc_q       <= '0;
         load_count  <= '0;
         bus.wr_en   <= 1'b0;
         bus.address <= '0;
         bus.data    <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         if (start_ok) begin
            len_q      <= '0;
            len_cnt_q  <= '0;
            index_q    <= '0;
            acc_q      <= '0;
            load_count <= '0;
         end
         if ((state_q == ST_LEN) && xfer) begin
            len_q     <= len_next;
            len_cnt_q <= len_cnt_q + 2'd1;
         end
         // Write is registered: it lands the cycle after the byte transfers.
         if ((state_q == ST_DATA) && xfer) begin
            bus.wr_en   <= 1'b1;
            bus.address <= BASE_ADDR + index_q;
            bus.data    <= bus.in_data;
            index_q     <= index_q + AW'(1);
            acc_q       <= acc_q + bus.in_data;
            load_count  <= load_count + AW'(1);
         end
      end
   end

endmodule
